pipe_stage_buf: RTL and testbench

Parametrised pipeline stage buffer that generalises the fixed ID/EXE-style stage register into a reusable valid/ready stage with configurable payload width, optional two-entry skid buffering, flush, NOP reload on emptying, and a bubble counter. It sits between any two MiniMIPS32 pipeline stages (IF/ID, ID/EXE, EXE/MEM, MEM/WB). The upstream stage packs its fields into one payload bus. Back-pressure travels as ready signals instead of a global stall vector.

---
 rtl/pipe_stage_buf.sv | 131 +++++++++++++
 tb/tb_pipe_stage_buf.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: reusable valid/ready pipeline stage register.
// Holds one payload (SKID=0) or up to two payloads (SKID=1) between two
// pipeline stages. It reloads RST_VAL as the NOP encoding whenever the main
// entry empties. It also counts cycles in which the downstream stage was ready
// but nothing was offered.
module pipe_stage_buf #(
    parameter int unsigned       DATA_W  = 64,
    parameter int unsigned       SKID    = 1,
    parameter logic [DATA_W-1:0] RST_VAL = '0,
    parameter int unsigned       CNT_W   = 16
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // Main entry: always the oldest payload held, drives the outputs directly.
    logic              m_v;
    logic [DATA_W-1:0] m_d;

    logic accept;
    logic issue;
    logic [CNT_W-1:0] bub_q;

    assign accept    = in_valid & in_ready;
    assign issue     = m_v & out_ready;
    assign out_valid = m_v;
    assign out_data  = m_d;
    assign bubble_cnt = bub_q;

    if (SKID != 0) begin : g_skid
        // Skid entry: catches the payload in flight when out_ready drops.
        logic              s_v;
        logic [DATA_W-1:0] s_d;
        logic              m_v_nx;
        logic              s_v_nx;
        logic [DATA_W-1:0] m_d_nx;
        logic [DATA_W-1:0] s_d_nx;

        // in_ready depends only on a register, so the upstream stage sees no
        // combinational path from out_ready.
        assign in_ready  = ~s_v;
        assign occupancy = {1'b0, m_v} + {1'b0, s_v};

        // Next-state selection for the two entries; the skid entry always holds
        // the younger payload, so ordering is preserved by shifting skid->main.
        always_comb begin
            m_v_nx = m_v;
            m_d_nx = m_d;
            s_v_nx = s_v;
            s_d_nx = s_d;
            if (!m_v) begin
                // Skid is necessarily empty here: it only fills behind a full main.
                if (accept) begin
                    m_v_nx = 1'b1;
                    m_d_nx = in_data;
                end
            end else if (issue) begin
                if (s_v) begin
                    m_d_nx = s_d;
                    if (accept) begin
                        s_d_nx = in_data;
                    end else begin
                        s_v_nx = 1'b0;
                        s_d_nx = RST_VAL;
                    end
                end else if (accept) begin
                    m_d_nx = in_data;
                end else begin
                    m_v_nx = 1'b0;
                    m_d_nx = RST_VAL;
                end
            end else if (accept) begin
                s_v_nx = 1'b1;
                s_d_nx = in_data;
            end
        end

        // Entry registers: reset and flush both discard everything held.
        always_ff @(posedge cpu_clk_50M) begin
            if (cpu_rst || flush) begin
                m_v <= 1'b0;
                m_d <= RST_VAL;
                s_v <= 1'b0;
                s_d <= RST_VAL;
            end else begin
                m_v <= m_v_nx;
                m_d <= m_d_nx;
                s_v <= s_v_nx;
                s_d <= s_d_nx;
            end
        end
    end else begin : g_single
        // Single register: refill is allowed in the same cycle the old payload
        // leaves, which keeps full throughput at the cost of a comb path.
        assign in_ready  = ~m_v | out_ready;
        assign occupancy = {1'b0, m_v};

        // Main entry register: load on accept, otherwise drain to NOP on issue.
        always_ff @(posedge cpu_clk_50M) begin
            if (cpu_rst || flush) begin
                m_v <= 1'b0;
                m_d <= RST_VAL;
            end else if (accept) begin
                m_v <= 1'b1;
                m_d <= in_data;
            end else if (issue) begin
                m_v <= 1'b0;
                m_d <= RST_VAL;
            end
        end
    end

    // Saturating bubble counter; flush does not clear it, only reset does.
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            bub_q <= '0;
        end else if (out_ready && !m_v && (bub_q != '1)) begin
            bub_q <= bub_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: three stage instances checked against a queue model.
//   inst0: SKID=1, 64-bit, RST_VAL=0, CNT_W=16
//   inst1: SKID=0, 64-bit, RST_VAL=DEADBEEF0BADF00D, CNT_W=16
//   inst2: SKID=1, 8-bit,  RST_VAL=5A, CNT_W=4
module tb_pipe_stage_buf;

    localparam int N = 3;
    localparam logic [63:0] RV1 = 64'hDEAD_BEEF_0BAD_F00D;
    localparam logic [7:0]  RV2 = 8'h5A;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        iv  [N];
    logic        orr [N];
    logic        fl  [N];
    logic [63:0] id  [N];

    logic        ir  [N];
    logic        ov  [N];
    logic [63:0] od  [N];
    logic [1:0]  occ [N];
    logic [15:0] bub [N];

    logic        ir0, ir1, ir2, ov0, ov1, ov2;
    logic [63:0] od0, od1;
    logic [7:0]  od2;
    logic [1:0]  occ0, occ1, occ2;
    logic [15:0] bub0, bub1;
    logic [3:0]  bub2;

    int errors = 0;
    int checks = 0;

    pipe_stage_buf #(.DATA_W(64), .SKID(1), .RST_VAL(64'h0), .CNT_W(16)) u_s1 (
        .cpu_clk_50M(clk), .cpu_rst(rst), .flush(fl[0]),
        .in_valid(iv[0]), .in_ready(ir0), .in_data(id[0]),
        .out_valid(ov0), .out_ready(orr[0]), .out_data(od0),
        .occupancy(occ0), .bubble_cnt(bub0));

    pipe_stage_buf #(.DATA_W(64), .SKID(0), .RST_VAL(RV1), .CNT_W(16)) u_s0 (
        .cpu_clk_50M(clk), .cpu_rst(rst), .flush(fl[1]),
        .in_valid(iv[1]), .in_ready(ir1), .in_data(id[1]),
        .out_valid(ov1), .out_ready(orr[1]), .out_data(od1),
        .occupancy(occ1), .bubble_cnt(bub1));

    pipe_stage_buf #(.DATA_W(8), .SKID(1), .RST_VAL(RV2), .CNT_W(4)) u_c4 (
        .cpu_clk_50M(clk), .cpu_rst(rst), .flush(fl[2]),
        .in_valid(iv[2]), .in_ready(ir2), .in_data(id[2][7:0]),
        .out_valid(ov2), .out_ready(orr[2]), .out_data(od2),
        .occupancy(occ2), .bubble_cnt(bub2));

    always_comb begin
        ir[0] = ir0;  ir[1] = ir1;  ir[2] = ir2;
        ov[0] = ov0;  ov[1] = ov1;  ov[2] = ov2;
        od[0] = od0;  od[1] = od1;  od[2] = {56'b0, od2};
        occ[0] = occ0; occ[1] = occ1; occ[2] = occ2;
        bub[0] = bub0; bub[1] = bub1; bub[2] = {12'b0, bub2};
    end

    // ---------------- reference model: a bounded FIFO per instance ----------
    int unsigned m_cnt [N];
    logic [63:0] m_q   [N][2];
    int unsigned m_bub [N];

    function automatic bit is_skid(int k);
        return k != 1;
    endfunction

    function automatic logic [63:0] rstv(int k);
        if (k == 1) return RV1;
        if (k == 2) return {56'b0, RV2};
        return 64'h0;
    endfunction

    function automatic logic [63:0] dmask(int k);
        return (k == 2) ? 64'hFF : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    function automatic int unsigned bmax(int k);
        return (k == 2) ? 15 : 65535;
    endfunction

    function automatic bit exp_ir(int k);
        if (is_skid(k)) return m_cnt[k] < 2;
        return (m_cnt[k] == 0) || orr[k];
    endfunction

    function automatic logic [63:0] exp_od(int k);
        return (m_cnt[k] > 0) ? m_q[k][0] : rstv(k);
    endfunction

    // Advance the model with the current inputs, then move to the next negedge.
    task automatic tick();
        bit acc;
        for (int k = 0; k < N; k++) begin
            if (rst) begin
                m_cnt[k] = 0;
                m_bub[k] = 0;
            end else begin
                if (orr[k] && m_cnt[k] == 0 && m_bub[k] < bmax(k)) m_bub[k]++;
                if (fl[k]) begin
                    m_cnt[k] = 0;
                end else begin
                    acc = iv[k] && exp_ir(k);
                    if (m_cnt[k] > 0 && orr[k]) begin
                        m_q[k][0] = m_q[k][1];
                        m_cnt[k]--;
                    end
                    if (acc) begin
                        m_q[k][m_cnt[k]] = id[k] & dmask(k);
                        m_cnt[k]++;
                    end
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int k = 0; k < N; k++) begin
            iv[k] = 1'b0; orr[k] = 1'b0; fl[k] = 1'b0; id[k] = '0;
        end
        #1;
    endtask

    // ---------------- directed tests -----------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < N; k++) begin
            iv[k] = 1'b1; id[k] = 64'hA5; orr[k] = 1'b0; fl[k] = 1'b0;
            m_cnt[k] = 0; m_bub[k] = 0;
        end
        tick();
        tick();
        rst = 1'b0;
        idle_all();
        for (int k = 0; k < N; k++) begin
            checks++; if (ov[k] !== 1'b0) begin errors++; $display("FAIL reset_valid inst%0d got %b want 0", k, ov[k]); end
            checks++; if (od[k] !== rstv(k)) begin errors++; $display("FAIL reset_data inst%0d got %h want %h", k, od[k], rstv(k)); end
            checks++; if (occ[k] !== 2'd0) begin errors++; $display("FAIL reset_occ inst%0d got %0d want 0", k, occ[k]); end
            checks++; if (bub[k] !== 16'd0) begin errors++; $display("FAIL reset_bub inst%0d got %0d want 0", k, bub[k]); end
            checks++; if (ir[k] !== 1'b1) begin errors++; $display("FAIL reset_in_ready inst%0d got %b want 1", k, ir[k]); end
        end
    endtask

    task automatic test_stream();
        logic [63:0] want;
        orr[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            iv[0] = (i < 3);
            id[0] = 64'(i + 1);
            #1;
            checks++; if (ir[0] !== 1'b1) begin errors++; $display("FAIL stream_in_ready c%0d got %b want 1", i, ir[0]); end
            if (i > 0) begin
                want = 64'(i);
                checks++; if (od[0] !== want || ov[0] !== 1'b1) begin errors++; $display("FAIL stream_data c%0d got %b/%h want 1/%h", i, ov[0], od[0], want); end
                checks++; if (occ[0] !== 2'd1) begin errors++; $display("FAIL stream_occ c%0d got %0d want 1", i, occ[0]); end
                checks++; if (bub[0] !== 16'd1) begin errors++; $display("FAIL stream_bub c%0d got %0d want 1", i, bub[0]); end
            end
            tick();
        end
        checks++; if (ov[0] !== 1'b0 || od[0] !== 64'h0) begin errors++; $display("FAIL stream_drain got %b/%h want 0/0", ov[0], od[0]); end
        idle_all();
    endtask

    task automatic test_skid_fill();
        // expected out_data, in_ready, occupancy per cycle
        logic [63:0] w_od  [8] = '{64'h0,  64'h10, 64'h10, 64'h10, 64'h10, 64'h11, 64'h12, 64'h0};
        logic        w_ir  [8] = '{1'b1,   1'b1,   1'b0,   1'b0,   1'b0,   1'b1,   1'b1,   1'b1};
        logic [1:0]  w_occ [8] = '{2'd0,   2'd1,   2'd2,   2'd2,   2'd2,   2'd1,   2'd1,   2'd0};
        logic        s_iv  [8] = '{1'b1,   1'b1,   1'b1,   1'b1,   1'b1,   1'b1,   1'b0,   1'b0};
        logic [63:0] s_id  [8] = '{64'h10, 64'h11, 64'h12, 64'h12, 64'h12, 64'h12, 64'h0,  64'h0};
        logic        s_or  [8] = '{1'b1,   1'b0,   1'b0,   1'b0,   1'b1,   1'b1,   1'b1,   1'b0};
        for (int i = 0; i < 8; i++) begin
            iv[0] = s_iv[i]; id[0] = s_id[i]; orr[0] = s_or[i];
            #1;
            checks++; if (od[0] !== w_od[i]) begin errors++; $display("FAIL skid_data c%0d got %h want %h", i, od[0], w_od[i]); end
            checks++; if (ir[0] !== w_ir[i]) begin errors++; $display("FAIL skid_in_ready c%0d got %b want %b", i, ir[0], w_ir[i]); end
            checks++; if (occ[0] !== w_occ[i]) begin errors++; $display("FAIL skid_occ c%0d got %0d want %0d", i, occ[0], w_occ[i]); end
            tick();
        end
        idle_all();
    endtask

    task automatic test_flush();
        iv[0] = 1'b1; id[0] = 64'h20; iv[1] = 1'b1; id[1] = 64'h30;
        tick();
        id[0] = 64'h21;
        tick();
        checks++; if (occ[0] !== 2'd2) begin errors++; $display("FAIL flush_pre_occ got %0d want 2", occ[0]); end
        checks++; if (occ[1] !== 2'd1) begin errors++; $display("FAIL flush_pre_occ_s0 got %0d want 1", occ[1]); end
        fl[0] = 1'b1; fl[1] = 1'b1;
        iv[0] = 1'b1; id[0] = 64'h77; iv[1] = 1'b1; id[1] = 64'h77;
        tick();
        fl[0] = 1'b0; fl[1] = 1'b0; iv[0] = 1'b0; iv[1] = 1'b0;
        orr[0] = 1'b1; orr[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (ov[0] !== 1'b0 || od[0] !== 64'h0) begin errors++; $display("FAIL flush_out c%0d got %b/%h want 0/0", i, ov[0], od[0]); end
            checks++; if (ov[1] !== 1'b0 || od[1] !== RV1) begin errors++; $display("FAIL flush_out_s0 c%0d got %b/%h want 0/%h", i, ov[1], od[1], RV1); end
            checks++; if (occ[0] !== 2'd0 || ir[0] !== 1'b1) begin errors++; $display("FAIL flush_occ_ready c%0d got %0d/%b want 0/1", i, occ[0], ir[0]); end
            tick();
        end
        idle_all();
    endtask

    task automatic test_passthrough();
        iv[1] = 1'b1; id[1] = 64'hA1; orr[1] = 1'b0;
        #1;
        checks++; if (ir[1] !== 1'b1 || od[1] !== RV1) begin errors++; $display("FAIL pass_empty got %b/%h want 1/%h", ir[1], od[1], RV1); end
        tick();
        id[1] = 64'hA2;
        #1;
        checks++; if (ir[1] !== 1'b0) begin errors++; $display("FAIL pass_blocked got %b want 0", ir[1]); end
        checks++; if (od[1] !== 64'hA1) begin errors++; $display("FAIL pass_hold got %h want a1", od[1]); end
        tick();
        orr[1] = 1'b1;
        #1;
        checks++; if (ir[1] !== 1'b1) begin errors++; $display("FAIL pass_comb_ready got %b want 1", ir[1]); end
        checks++; if (od[1] !== 64'hA1) begin errors++; $display("FAIL pass_still got %h want a1", od[1]); end
        tick();
        iv[1] = 1'b0;
        #1;
        checks++; if (ov[1] !== 1'b1 || od[1] !== 64'hA2) begin errors++; $display("FAIL pass_replace got %b/%h want 1/a2", ov[1], od[1]); end
        tick();
        checks++; if (ov[1] !== 1'b0 || od[1] !== RV1) begin errors++; $display("FAIL pass_drain got %b/%h want 0/%h", ov[1], od[1], RV1); end
        idle_all();
    endtask

    task automatic test_bubble_sat();
        int unsigned want;
        orr[2] = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            want = (i > 15) ? 15 : i;
            checks++; if (bub[2] !== 16'(want)) begin errors++; $display("FAIL bub_count c%0d got %0d want %0d", i, bub[2], want); end
        end
        fl[2] = 1'b1;
        tick();
        fl[2] = 1'b0;
        checks++; if (bub[2] !== 16'd15) begin errors++; $display("FAIL bub_after_flush got %0d want 15", bub[2]); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        orr[2] = 1'b0;
        #1;
        checks++; if (bub[2] !== 16'd0) begin errors++; $display("FAIL bub_after_rst got %0d want 0", bub[2]); end
        checks++; if (bub[0] !== 16'd0) begin errors++; $display("FAIL bub_after_rst_i0 got %0d want 0", bub[0]); end
        idle_all();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int k = 0; k < N; k++) begin
                iv[k]  = ($urandom_range(0, 1) == 1);
                id[k]  = {$urandom, $urandom};
                orr[k] = ($urandom_range(0, 9) < 7);
                fl[k]  = ($urandom_range(0, 39) == 0);
            end
            #1;
            for (int k = 0; k < N; k++) begin
                checks++; if (ov[k] !== (m_cnt[k] > 0)) begin errors++; $display("FAIL rnd_valid inst%0d c%0d got %b want %b", k, c, ov[k], m_cnt[k] > 0); end
                checks++; if (od[k] !== exp_od(k)) begin errors++; $display("FAIL rnd_data inst%0d c%0d got %h want %h", k, c, od[k], exp_od(k)); end
                checks++; if (occ[k] !== 2'(m_cnt[k])) begin errors++; $display("FAIL rnd_occ inst%0d c%0d got %0d want %0d", k, c, occ[k], m_cnt[k]); end
                checks++; if (ir[k] !== exp_ir(k)) begin errors++; $display("FAIL rnd_in_ready inst%0d c%0d got %b want %b", k, c, ir[k], exp_ir(k)); end
                checks++; if (bub[k] !== 16'(m_bub[k])) begin errors++; $display("FAIL rnd_bub inst%0d c%0d got %0d want %0d", k, c, bub[k], m_bub[k]); end
            end
            tick();
        end
        rst = 1'b0;
        idle_all();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_skid_fill();
        test_flush();
        test_passthrough();
        test_bubble_sat();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
